// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that reuses one external 4-bit adder, one nibble per clock.
// Optional NSA_SUB_EN adds a sub input that turns the block into a subtractor.
module nibble_serial_adder #(
  parameter int WORDS = 4,
  localparam int W = 4 * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef NSA_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic [3:0]   add_n1,
  output logic [3:0]   add_n2,
  output logic         add_ci,
  input  logic [3:0]   add_sum,
  input  logic         add_co
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   result_q, result_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   b_eff;
  logic           ci_eff;

  // Subtraction is a + ~b + 1; cout then reads as "no borrow".
`ifdef NSA_SUB_EN
  assign b_eff  = sub ? ~b : b;
  assign ci_eff = sub ? 1'b1 : cin;
`else
  assign b_eff  = b;
  assign ci_eff = cin;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = ci_eff;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == IW'(i)) result_d[4*i +: 4] = add_sum;
        end
        carry_d = add_co;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_co;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Adder pins decode only from registered state so the external path starts clean each cycle.
  always_comb begin
    add_n1 = 4'h0;
    add_n2 = 4'h0;
    add_ci = 1'b0;
    if (state_q == RUN) begin
      add_ci = carry_q;
      for (int i = 0; i < WORDS; i++) begin
        if (idx_q == IW'(i)) begin
          add_n1 = a_q[4*i +: 4];
          add_n2 = b_q[4*i +: 4];
        end
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule
